ccg_lut_bank: RTL and testbench
===============================

Name: ccg_lut_bank

Overview:
- Parametrised, registered successor to our fixed two-input generated function benchmarks.
- Holds N_OUT programmable truth tables over N_IN inputs. Tables are loaded through a serial configuration stream.
- Each accepted input vector is evaluated against all tables and returned through a valid/ready output register.
- Used as a reconfigurable stand-in for generated combinational benchmarks inside sequential test harnesses.

Parameters:
- N_IN, 2, number of function inputs (1..8)
- N_OUT, 18, number of function outputs (1..64)
- TBITS, N_OUT*2**N_IN (derived localparam), total table bits

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cfg_start  input  1  one-cycle pulse; (re)starts a table load
- cfg_valid  input  1  cfg_data valid
- cfg_data  input  1  serial table bit
- cfg_ready  output  1  bank accepts a cfg bit
- cfg_done  output  1  one-cycle pulse when the last table bit is accepted
- in_valid  input  1  x valid
- x  input  N_IN  input vector
- in_ready  output  1  bank accepts x
- out_valid  output  1  f valid
- f  output  N_OUT  result; f[o] = T[o][x]
- out_ready  input  1  downstream accepts f

Behaviour:
- Reset: clk and rst_n are the only clock and reset. rst_n is asynchronous and active-low; assertion takes effect immediately, including mid-load or mid-transfer.
  - State goes to EMPTY.
  - All table bits, f, out_valid, cfg_done and the load counter are cleared to 0.
  - cfg_ready = 0, in_ready = 0.
- States:
  - EMPTY, LOAD and RUN are encoded in a 2-bit register.
  - EMPTY: no valid tables. in_ready = 0, cfg_ready = 0.
  - LOAD: cfg_ready = 1, in_ready = 0.
    - Each cycle with cfg_valid && cfg_ready accepts one bit and increments cnt (width $clog2(TBITS+1)).
    - Bit k of the stream (k = 0..TBITS-1) is written to T[k / 2**N_IN][k % 2**N_IN].
    - The cycle that accepts bit k = TBITS-1 moves the state to RUN and asserts cfg_done for exactly one cycle after that edge.
  - RUN:
    - cfg_ready = 0.
    - in_ready = !out_valid || out_ready.
    - On in_valid && in_ready, f <= lookup(x) and out_valid <= 1 at the next edge. Latency is one clock.
    - When out_valid && out_ready && !(in_valid && in_ready), out_valid <= 0 and f holds its last value.
    - Back-to-back transfers sustain one result per cycle.
    - While out_valid && !out_ready: f and out_valid hold, and in_ready = 0.
- cfg_start, in any state:
  - Next state is LOAD and cnt <= 0. out_valid is forced to 0, so any pending result is dropped.
  - Table contents are not cleared; they are overwritten bit by bit.
  - cfg_start during LOAD restarts the count at 0.
  - cfg_start has priority: a cfg bit or x presented in the same cycle is not accepted.
- cfg_valid outside LOAD is ignored.
- x is sampled only on an accepted transfer. The combinational lookup never drives f directly.
- The lookup is a mux per output indexed by x. Index width is N_IN, with no wrap issues because 2**N_IN entries always exist.

Optional Feature:
- Macro: CCG_LUT_READBACK_EN.
- Defined: adds an output port cfg_rdata (1 bit).
  - In LOAD, on each accepted bit k, cfg_rdata registers the old value of T[k / 2**N_IN][k % 2**N_IN] before it is overwritten. This allows non-destructive verification by reloading the same stream.
  - cfg_rdata resets to 0 and holds outside accepted cycles.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Test Plan:
Scenarios 1-4 use N_IN = 2, N_OUT = 3, TBITS = 12.
1. Reset, then in_valid = 1 with x = 3 for 5 cycles -> in_ready = 0, out_valid = 0, f = 0 throughout.
2. Pulse cfg_start, then stream bits 0,0,0,1, 0,1,1,0, 1,1,1,1 (f0 = AND, f1 = XOR, f2 = 1) with cfg_valid held high.
   - cfg_done pulses exactly once, on the cycle after the 12th bit.
   - Then x = 3 gives f = 3'b101 and x = 1 gives f = 3'b110, each one cycle after acceptance.
3. Stream x = 0,1,2,3 back-to-back with out_ready = 1 -> f = 3'b100, 3'b110, 3'b110, 3'b101 on consecutive cycles.
   - Then hold out_ready = 0 for 3 cycles -> f and out_valid stable, in_ready = 0.
4. Stop after 6 bits of a reload and pulse cfg_start. Then stream the full all-ones table -> every x gives f = 3'b111.
   - Separately, deassert rst_n mid-load -> state EMPTY and all outputs 0 immediately, without waiting for a clock edge.
5. With CCG_LUT_READBACK_EN defined, reload the scenario-2 stream -> cfg_rdata reproduces 0,0,0,1, 0,1,1,0, 1,1,1,1, one cycle after each accepted bit.
6. Default parameters (N_IN = 2, N_OUT = 18, 72 bits):
   - Load a table where T[o][i] = (o + i) % 2 -> x = 2 gives f = 18'h2AAAA (odd outputs = 1) and x = 1 gives f = 18'h15555.

Source files
------------

// File: rtl/ccg_lut_bank.sv
// N_OUT programmable N_IN-input truth tables, loaded over a serial bit stream and evaluated
// per accepted x into a valid/ready output register. Define CCG_LUT_READBACK_EN for cfg_rdata.
module ccg_lut_bank #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_data,
    output logic             cfg_ready,
    output logic             cfg_done,
`ifdef CCG_LUT_READBACK_EN
    output logic             cfg_rdata,
`endif
    input  logic             in_valid,
    input  logic [N_IN-1:0]  x,
    output logic             in_ready,
    output logic             out_valid,
    output logic [N_OUT-1:0] f,
    input  logic             out_ready
);
    localparam int DEPTH = 2**N_IN;
    localparam int TBITS = N_OUT*DEPTH;
    localparam int CNT_W = $clog2(TBITS+1);
    localparam int IDX_W = $clog2(TBITS);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_LOAD  = 2'b01,
        ST_RUN   = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TBITS-1:0] tbl_q, tbl_d;
    logic [N_OUT-1:0] f_q, f_d;
    logic             ov_q, ov_d;
    logic             done_q, done_d;
    logic [N_OUT-1:0] lut_c;
    logic [IDX_W-1:0] wr_idx;
    logic             cfg_acc, in_acc, last_bit;

    // Stream bit k lands at flat position k, i.e. table o occupies bits [o*DEPTH +: DEPTH].
    for (genvar o = 0; o < N_OUT; o++) begin : g_lut
        logic [DEPTH-1:0] row;
        assign row      = tbl_q[o*DEPTH +: DEPTH];
        assign lut_c[o] = row[x];
    end

    assign cfg_ready = (state_q == ST_LOAD);
    assign in_ready  = (state_q == ST_RUN) && (!ov_q || out_ready);
    assign cfg_acc   = cfg_valid && cfg_ready && !cfg_start;
    assign in_acc    = in_valid && in_ready && !cfg_start;
    assign wr_idx    = cnt_q[IDX_W-1:0];
    assign last_bit  = (cnt_q == CNT_W'(TBITS-1));

    assign cfg_done  = done_q;
    assign out_valid = ov_q;
    assign f         = f_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tbl_d   = tbl_q;
        f_d     = f_q;
        ov_d    = ov_q;
        done_d  = 1'b0;
        if (cfg_start) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            ov_d    = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (cfg_acc) begin
                        tbl_d[wr_idx] = cfg_data;
                        cnt_d         = cnt_q + CNT_W'(1);
                        if (last_bit) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (in_acc) begin
                        f_d  = lut_c;
                        ov_d = 1'b1;
                    end else if (ov_q && out_ready) begin
                        ov_d = 1'b0;
                    end
                end
                ST_EMPTY: ;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            cnt_q   <= '0;
            tbl_q   <= '0;
            f_q     <= '0;
            ov_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tbl_q   <= tbl_d;
            f_q     <= f_d;
            ov_q    <= ov_d;
            done_q  <= done_d;
        end
    end

`ifdef CCG_LUT_READBACK_EN
    logic rdata_q, rdata_d;

    // Returns the bit about to be overwritten so a reload of the same stream verifies it.
    always_comb begin
        rdata_d = rdata_q;
        if (cfg_acc) begin
            rdata_d = tbl_q[wr_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign cfg_rdata = rdata_q;
`endif

endmodule

// File: tb/tb_ccg_lut_bank.sv
// Directed bench for ccg_lut_bank: a 3-output bank checked every cycle against a table model,
// plus an 18-output default bank with literal expectations.
module tb_ccg_lut_bank;
    localparam int NI  = 2;
    localparam int NOA = 3;
    localparam int NOB = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic            a_start, a_cvalid, a_cdata, a_cready, a_done;
    logic            a_ivalid, a_iready, a_ovalid, a_oready;
    logic [NI-1:0]   a_x;
    logic [NOA-1:0]  a_f;
    logic            b_start, b_cvalid, b_cdata, b_cready, b_done;
    logic            b_ivalid, b_iready, b_ovalid, b_oready;
    logic [NI-1:0]   b_x;
    logic [NOB-1:0]  b_f;
`ifdef CCG_LUT_READBACK_EN
    logic            a_rdata, b_rdata;
`endif

    ccg_lut_bank #(.N_IN(NI), .N_OUT(NOA)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(a_start), .cfg_valid(a_cvalid), .cfg_data(a_cdata),
        .cfg_ready(a_cready), .cfg_done(a_done),
`ifdef CCG_LUT_READBACK_EN
        .cfg_rdata(a_rdata),
`endif
        .in_valid(a_ivalid), .x(a_x), .in_ready(a_iready),
        .out_valid(a_ovalid), .f(a_f), .out_ready(a_oready)
    );

    ccg_lut_bank dut_b (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(b_start), .cfg_valid(b_cvalid), .cfg_data(b_cdata),
        .cfg_ready(b_cready), .cfg_done(b_done),
`ifdef CCG_LUT_READBACK_EN
        .cfg_rdata(b_rdata),
`endif
        .in_valid(b_ivalid), .x(b_x), .in_ready(b_iready),
        .out_valid(b_ovalid), .f(b_f), .out_ready(b_oready)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model of bank A: tables as T[o][i], a stream position, a mode and the held result.
    logic       m_tbl [NOA][4];
    int         m_mode;          // 0 empty, 1 load, 2 run
    logic [3:0] m_k;             // stream position k; row = k/4, column = k%4
    logic       m_ov, m_done, m_rdata;
    logic [NOA-1:0] m_f;
    logic       m_inrdy;
    assign m_inrdy = (m_mode == 2) && (!m_ov || a_oready);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tbl   <= '{default: 1'b0};
            m_mode  <= 0;
            m_k     <= '0;
            m_ov    <= 1'b0;
            m_done  <= 1'b0;
            m_rdata <= 1'b0;
            m_f     <= '0;
        end else begin
            m_done <= 1'b0;
            if (a_start) begin
                m_mode <= 1;
                m_k    <= '0;
                m_ov   <= 1'b0;
            end else if (m_mode == 1 && a_cvalid) begin
                m_rdata                   <= m_tbl[m_k[3:2]][m_k[1:0]];
                m_tbl[m_k[3:2]][m_k[1:0]] <= a_cdata;
                m_k                       <= m_k + 4'd1;
                if (m_k == 4'd11) begin
                    m_mode <= 2;
                    m_done <= 1'b1;
                end
            end else if (m_inrdy && a_ivalid) begin
                m_f  <= {m_tbl[2][a_x], m_tbl[1][a_x], m_tbl[0][a_x]};
                m_ov <= 1'b1;
            end else if (m_ov && a_oready) begin
                m_ov <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("a_cfg_ready", 32'(a_cready), 32'(m_mode == 1));
        chk("a_in_ready",  32'(a_iready), 32'(m_inrdy));
        chk("a_out_valid", 32'(a_ovalid), 32'(m_ov));
        chk("a_f",         32'(a_f),      32'(m_f));
        chk("a_cfg_done",  32'(a_done),   32'(m_done));
`ifdef CCG_LUT_READBACK_EN
        chk("a_cfg_rdata", 32'(a_rdata),  32'(m_rdata));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [11:0] s);
        for (int i = 0; i < 12; i++) begin
            a_cvalid = 1'b1;
            a_cdata  = s[i];
            tick();
        end
        a_cvalid = 1'b0;
    endtask

    logic [11:0] s2;
    logic [2:0]  exp3 [4];

    initial begin
        s2   = 12'hF68;   // stream bits 0..11 = 0,0,0,1, 0,1,1,0, 1,1,1,1
        exp3 = '{3'b100, 3'b110, 3'b110, 3'b101};
        rst_n = 1'b1;
        {a_start, a_cvalid, a_cdata, a_ivalid} = '0;
        {b_start, b_cvalid, b_cdata, b_ivalid} = '0;
        a_x = '0; b_x = '0;
        a_oready = 1'b1; b_oready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;

        // Scenario 1: inputs ignored while empty
        a_ivalid = 1'b1;
        a_x      = 2'd3;
        repeat (5) begin
            tick();
            chk("s1_in_ready", 32'(a_iready), 32'd0);
            chk("s1_out_valid", 32'(a_ovalid), 32'd0);
            chk("s1_f", 32'(a_f), 32'd0);
        end
        a_ivalid = 1'b0;

        // Scenario 2: load AND / XOR / ONE
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("s2_cfg_ready", 32'(a_cready), 32'd1);
        load_a(s2);
        chk("s2_cfg_done", 32'(a_done), 32'd1);
        a_ivalid = 1'b1;
        a_x      = 2'd3;
        tick();
        chk("s2_cfg_done_clr", 32'(a_done), 32'd0);
        chk("s2_f_x3", 32'(a_f), 32'b101);
        chk("s2_ov_x3", 32'(a_ovalid), 32'd1);
        a_x = 2'd1;
        tick();
        chk("s2_f_x1", 32'(a_f), 32'b110);
        a_ivalid = 1'b0;
        tick();
        chk("s2_ov_drain", 32'(a_ovalid), 32'd0);
        chk("s2_f_hold", 32'(a_f), 32'b110);

        // Scenario 3: back-to-back, then backpressure
        a_ivalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_x = 2'(i);
            tick();
            chk("s3_f_stream", 32'(a_f), 32'(exp3[i]));
        end
        a_x      = 2'd0;
        a_oready = 1'b0;
        #1;
        chk("s3_in_ready_bp", 32'(a_iready), 32'd0);
        repeat (3) begin
            tick();
            chk("s3_f_stall", 32'(a_f), 32'b101);
            chk("s3_ov_stall", 32'(a_ovalid), 32'd1);
            chk("s3_in_ready_stall", 32'(a_iready), 32'd0);
        end
        a_oready = 1'b1;
        tick();
        chk("s3_f_resume", 32'(a_f), 32'b100);
        a_ivalid = 1'b0;
        tick();
        chk("s3_ov_drain", 32'(a_ovalid), 32'd0);

        // Pending result dropped by cfg_start, which also wins over a same-cycle cfg bit
        a_ivalid = 1'b1;
        a_x      = 2'd1;
        a_oready = 1'b0;
        tick();
        chk("drop_ov_before", 32'(a_ovalid), 32'd1);
        a_ivalid = 1'b0;
        a_start  = 1'b1;
        a_cvalid = 1'b1;
        a_cdata  = 1'b0;
        tick();
        a_start  = 1'b0;
        a_oready = 1'b1;
        chk("drop_ov_after", 32'(a_ovalid), 32'd0);

        // Scenario 4: partial load, restart, full all-ones table
        for (int i = 0; i < 6; i++) begin
            a_cvalid = 1'b1;
            a_cdata  = 1'b1;
            tick();
        end
        a_cvalid = 1'b0;
        tick();
        chk("s4_partial_no_done", 32'(a_done), 32'd0);
        a_start  = 1'b1;
        a_cvalid = 1'b1;
        a_cdata  = 1'b0;
        tick();
        a_start = 1'b0;
        load_a(12'hFFF);
        chk("s4_cfg_done", 32'(a_done), 32'd1);
        a_ivalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_x = 2'(i);
            tick();
            chk("s4_f_ones", 32'(a_f), 32'b111);
        end
        a_ivalid = 1'b0;

        // Asynchronous reset in the middle of a load
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_cvalid = 1'b1;
            a_cdata  = 1'b1;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cfg_ready", 32'(a_cready), 32'd0);
        chk("rst_in_ready", 32'(a_iready), 32'd0);
        chk("rst_out_valid", 32'(a_ovalid), 32'd0);
        chk("rst_f", 32'(a_f), 32'd0);
        chk("rst_cfg_done", 32'(a_done), 32'd0);
        a_cvalid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Scenario 5: load twice; the second load returns the first stream
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        load_a(s2);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
`ifdef CCG_LUT_READBACK_EN
        for (int i = 0; i < 12; i++) begin
            a_cvalid = 1'b1;
            a_cdata  = s2[i];
            tick();
            chk("s5_cfg_rdata", 32'(a_rdata), 32'(s2[i]));
        end
        a_cvalid = 1'b0;
`else
        load_a(s2);
`endif
        a_ivalid = 1'b1;
        a_x      = 2'd3;
        tick();
        chk("s5_f_x3", 32'(a_f), 32'b101);
        a_ivalid = 1'b0;
        tick();

        // Scenario 6: default bank, T[o][i] = (o + i) % 2
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int k = 0; k < 72; k++) begin
            b_cvalid = 1'b1;
            b_cdata  = 1'(((k / 4) + (k % 4)) % 2);
            tick();
`ifdef CCG_LUT_READBACK_EN
            if (k == 0) chk("s6_cfg_rdata0", 32'(b_rdata), 32'd0);
`endif
            if (k == 70) chk("s6_no_early_done", 32'(b_done), 32'd0);
        end
        b_cvalid = 1'b0;
        chk("s6_cfg_done", 32'(b_done), 32'd1);
        chk("s6_cfg_ready_run", 32'(b_cready), 32'd0);
        b_ivalid = 1'b1;
        b_x      = 2'd2;
        tick();
        chk("s6_f_x2", 32'(b_f), 32'h2AAAA);
        chk("s6_ov", 32'(b_ovalid), 32'd1);
        b_x = 2'd1;
        tick();
        chk("s6_f_x1", 32'(b_f), 32'h15555);
        chk("s6_in_ready", 32'(b_iready), 32'd1);
        b_ivalid = 1'b0;
        tick();
        chk("s6_ov_drain", 32'(b_ovalid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
